sender: RTL and testbench



---
 rtl/sender_pkg.sv | 23 ++
 rtl/ack_sync.sv | 24 ++
 rtl/sender.sv | 94 +++++++++
 tb/tb_sender.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sender_pkg.sv
// rtl/sender_pkg.sv - shared types, constants and frame builder for the dual-rail sender
package sender_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        RTZ   = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int         FRAME_LEN = 8;
    localparam logic [1:0] START_PAT = 2'b10;
    localparam logic [2:0] LAST_BIT  = 3'(FRAME_LEN - 1);

    // Up and Down together are contradictory, so they collapse to a no-op before parity.
    function automatic logic [FRAME_LEN-1:0] build_frame(input logic ch2, input logic ch1,
                                                         input logic up, input logic down);
        logic [1:0] cmd;
        cmd = (up && down) ? 2'b00 : {up, down};
        return {START_PAT, ch2, ch1, cmd, ^{ch2, ch1, cmd}, 1'b0};
    endfunction

endpackage

// File: rtl/ack_sync.sv
// rtl/ack_sync.sv - two-flop synchronizer for the receiver acknowledge
module ack_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/sender.sv
// rtl/sender.sv - four-phase dual-rail serial transmitter for channel/direction commands
module sender
    import sender_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic go,
    input  logic Ch1,
    input  logic Ch2,
    input  logic Up,
    input  logic Down,
    input  logic ack,
    output logic Bit0_Out,
    output logic Bit1_Out,
    output logic dt,
    output logic comp
);

    state_e                 state_q;
    logic [FRAME_LEN-1:0]   frame_q;
    logic [2:0]             cnt_q;
    logic                   bit0_q;
    logic                   bit1_q;
    logic                   dt_q;
    logic                   comp_q;
    logic                   ack_s;
    logic [FRAME_LEN-1:0]   new_frame;

    ack_sync u_ack_sync (
        .clk     (clk),
        .reset   (reset),
        .async_i (ack),
        .sync_o  (ack_s)
    );

    assign new_frame = build_frame(Ch2, Ch1, Up, Down);

    // frame_q shifts left as bits go out, so the bit on the rails is always frame_q[MSB].
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            frame_q <= '0;
            cnt_q   <= '0;
            bit0_q  <= 1'b0;
            bit1_q  <= 1'b0;
            dt_q    <= 1'b0;
            comp_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (go) begin
                        frame_q <= new_frame;
                        cnt_q   <= '0;
                        bit1_q  <= new_frame[FRAME_LEN-1];
                        bit0_q  <= ~new_frame[FRAME_LEN-1];
                        dt_q    <= 1'b1;
                        comp_q  <= 1'b0;
                        state_q <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (ack_s) begin
                        bit0_q  <= 1'b0;
                        bit1_q  <= 1'b0;
                        dt_q    <= 1'b0;
                        state_q <= RTZ;
                    end
                end
                RTZ: begin
                    if (!ack_s) begin
                        if (cnt_q != LAST_BIT) begin
                            cnt_q   <= cnt_q + 3'd1;
                            frame_q <= {frame_q[FRAME_LEN-2:0], 1'b0};
                            bit1_q  <= frame_q[FRAME_LEN-2];
                            bit0_q  <= ~frame_q[FRAME_LEN-2];
                            dt_q    <= 1'b1;
                            state_q <= DRIVE;
                        end else begin
                            comp_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Bit0_Out = bit0_q;
    assign Bit1_Out = bit1_q;
    assign dt       = dt_q;
    assign comp     = comp_q;

endmodule

// File: tb/tb_sender.sv
// tb/tb_sender.sv - scoreboard bench for the dual-rail sender
module tb_sender;

    logic clk = 1'b0;
    logic reset, go, Ch1, Ch2, Up, Down, ack;
    logic Bit0_Out, Bit1_Out, dt, comp;

    int n_checks = 0;
    int n_pass   = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    sender dut (
        .clk      (clk),
        .reset    (reset),
        .go       (go),
        .Ch1      (Ch1),
        .Ch2      (Ch2),
        .Up       (Up),
        .Down     (Down),
        .ack      (ack),
        .Bit0_Out (Bit0_Out),
        .Bit1_Out (Bit1_Out),
        .dt       (dt),
        .comp     (comp)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [7:0] model(input logic c2, input logic c1,
                                         input logic u, input logic d);
        logic u2, d2;
        u2 = u & ~d;
        d2 = d & ~u;
        return {2'b10, c2, c1, u2, d2, c2 ^ c1 ^ u2 ^ d2, 1'b0};
    endfunction

    task automatic push_frame(input logic [7:0] f);
        for (int i = 7; i >= 0; i--) exp_q.push_back(f[i]);
    endtask

    task automatic start(input logic c2, input logic c1, input logic u, input logic d,
                         input logic [7:0] f, input bit keep_go);
        @(negedge clk);
        Ch2 = c2; Ch1 = c1; Up = u; Down = d; go = 1'b1;
        push_frame(f);
        @(negedge clk);
        if (!keep_go) begin
            go = 1'b0;
            {Ch2, Ch1, Up, Down} = 4'($urandom);
        end
        check("go_lat", dt, 1);
    endtask

    task automatic do_bit(input int hold, input int exp_rise);
        int n;
        bit e;
        bit seen;
        n = 0;
        while (!dt && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!dt) begin
            check("dt_timeout", dt, 1);
            return;
        end
        check("rise_lat", n, exp_rise);
        if (exp_q.size() == 0) begin
            check("queue_empty", exp_q.size(), 1);
            return;
        end
        e = exp_q.pop_front();
        check("bit1", Bit1_Out, e);
        check("bit0", Bit0_Out, !e);
        ack = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dt && n < 20);
        check("drop_lat", n, 3);
        if (hold > 0) begin
            seen = 0;
            repeat (hold) begin
                @(negedge clk);
                if (dt || Bit0_Out || Bit1_Out) seen = 1;
            end
            check("hold_rz", seen, 0);
        end
        ack = 1'b0;
    endtask

    task automatic finish_frame(input int left);
        int n;
        n = 0;
        while (!comp && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("comp_lat", n, 3);
        check("comp_dt", dt, 0);
        check("queue_left", exp_q.size(), left);
    endtask

    task automatic run_frame(input logic c2, input logic c1, input logic u, input logic d,
                             input logic [7:0] f);
        start(c2, c1, u, d, f, 0);
        for (int i = 0; i < 8; i++) do_bit(0, (i == 0) ? 0 : 3);
        finish_frame(0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] f;
        bit bad;
        logic [3:0] r;
        reset = 1'b0; go = 1'b0; ack = 1'b0;
        Ch1 = 1'b0; Ch2 = 1'b0; Up = 1'b0; Down = 1'b0;

        bad = 0;
        for (int i = 0; i < 20; i++) begin
            #5 ack = ~ack;
            if (Bit0_Out || Bit1_Out || dt || comp) bad = 1;
        end
        check("reset_quiet", bad, 0);
        ack = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_outs", {Bit0_Out, Bit1_Out, dt, comp}, 0);

        ack = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_ack", {dt, comp}, 0);
        ack = 1'b0;
        repeat (4) @(negedge clk);

        run_frame(0, 1, 1, 0, 8'b1001_1000);
        run_frame(1, 1, 0, 1, 8'b1011_0110);
        run_frame(0, 1, 1, 1, 8'b1001_0010);

        ack = 1'b1;
        repeat (6) @(negedge clk);
        check("done_ack", {comp, dt}, 2'b10);
        ack = 1'b0;
        repeat (4) @(negedge clk);

        f = model(1, 0, 0, 1);
        start(1, 0, 0, 1, f, 0);
        do_bit(20, 0);
        for (int i = 1; i < 8; i++) do_bit(0, 3);
        finish_frame(0);

        r = 4'($urandom);
        f = model(r[3], r[2], r[1], r[0]);
        start(r[3], r[2], r[1], r[0], f, 0);
        for (int i = 0; i < 4; i++) do_bit(0, (i == 0) ? 0 : 3);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1 check("rst_async", {Bit0_Out, Bit1_Out, dt, comp}, 0);
        exp_q.delete();
        ack = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_idle", {dt, comp}, 0);
        run_frame(0, 1, 1, 0, 8'b1001_1000);

        f = model(0, 0, 1, 0);
        start(0, 0, 1, 0, f, 1);
        push_frame(f);
        for (int i = 0; i < 8; i++) do_bit(0, (i == 0) ? 0 : 3);
        finish_frame(8);
        do_bit(0, 1);
        go = 1'b0;
        for (int i = 1; i < 8; i++) do_bit(0, 3);
        finish_frame(0);

        for (int k = 0; k < 3; k++) begin
            r = 4'($urandom);
            run_frame(r[3], r[2], r[1], r[0], model(r[3], r[2], r[1], r[0]));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
